// File: rtl/du_dump_sender_pkg.sv
// -----------------------------------------------------------------------------
// du_dump_sender_pkg
// Shared definitions for the debug-unit dump sender:
//   - default widths for the source word, UART byte and source address
//   - byte-per-word count and the width of the byte index
//   - FSM state encoding
// -----------------------------------------------------------------------------
package du_dump_sender_pkg;

  localparam int DEF_NB_DATA    = 32;
  localparam int DEF_NB_BYTE    = 8;
  localparam int DEF_NB_ADDR    = 8;
  localparam int BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;
  localparam int IDX_W          = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } dump_state_e;

endpackage : du_dump_sender_pkg

// File: rtl/du_dump_sender_if.sv
// -----------------------------------------------------------------------------
// du_dump_sender_if
// Bundles the source read port and the UART transmit handshake.
//   master (dump sender): drives o_rd_enable, o_rd_addr, o_tx_data, o_tx_start;
//                         receives i_rd_data, i_tx_done
//   slave  (source + UART): the opposite directions
// Signal names are written from the dump sender's point of view.
// -----------------------------------------------------------------------------
interface du_dump_sender_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8
);

  logic               o_rd_enable;
  logic [NB_ADDR-1:0] o_rd_addr;
  logic [NB_DATA-1:0] i_rd_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;

  modport master (
    output o_rd_enable,
    output o_rd_addr,
    output o_tx_data,
    output o_tx_start,
    input  i_rd_data,
    input  i_tx_done
  );

  modport slave (
    input  o_rd_enable,
    input  o_rd_addr,
    input  o_tx_data,
    input  o_tx_start,
    output i_rd_data,
    output i_tx_done
  );

endinterface : du_dump_sender_if

// File: rtl/du_dump_sender_word_shifter.sv
// -----------------------------------------------------------------------------
// du_word_shifter
// Holds one source word and presents it one byte at a time.
//   i_clock  : system clock
//   i_reset  : asynchronous active-low reset, clears the word
//   i_load   : capture i_word (takes priority over i_shift)
//   i_shift  : advance to the next byte in the send direction
//   i_word   : word to capture
//   o_byte   : current byte (low byte when LSB_FIRST, else high byte)
// o_byte is a fixed slice of the register, so it is glitch-free and stays
// stable until the next load or shift.
// -----------------------------------------------------------------------------
module du_word_shifter #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_byte
);

  logic [NB_DATA-1:0] r_shift;
  logic [NB_DATA-1:0] w_next;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      // Low byte goes out first; move the next byte down into [7:0].
      assign w_next = r_shift >> NB_BYTE;
      assign o_byte = r_shift[NB_BYTE-1:0];
    end else begin : g_msb
      // High byte goes out first; move the next byte up into the top lane.
      assign w_next = r_shift << NB_BYTE;
      assign o_byte = r_shift[NB_DATA-1 -: NB_BYTE];
    end
  endgenerate

  // Word register: load a fresh word or step one byte
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= {NB_DATA{1'b0}};
    end else if (i_load) begin
      r_shift <= i_word;
    end else if (i_shift) begin
      r_shift <= w_next;
    end else begin
      r_shift <= r_shift;
    end
  end

endmodule : du_word_shifter

// File: rtl/du_dump_sender.sv
// -----------------------------------------------------------------------------
// du_dump_sender
// Debug-unit transmit sequencer. On an accepted start it reads i_count words
// beginning at i_base_addr from a synchronous-read source and sends each word
// as four bytes to the debug UART using its tx_start/tx_done handshake.
//   i_clock      : system clock
//   i_reset      : asynchronous active-low reset
//   i_start      : dump request, only honoured in IDLE
//   i_base_addr  : first word address (sampled with an accepted start)
//   i_count      : number of words (sampled with an accepted start), 0 = none
//   bus          : master side of du_dump_sender_if (read port + UART)
//   o_busy       : high while not IDLE
//   o_done       : one-cycle pulse after the section completes
// Every output is a register or a decode of the state register.
// -----------------------------------------------------------------------------
module du_dump_sender
  import du_dump_sender_pkg::*;
#(
  parameter int NB_DATA   = DEF_NB_DATA,
  parameter int NB_BYTE   = DEF_NB_BYTE,
  parameter int NB_ADDR   = DEF_NB_ADDR,
  parameter int LSB_FIRST = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_base_addr,
  input  logic [NB_ADDR-1:0] i_count,
  du_dump_sender_if.master   bus,
  output logic               o_busy,
  output logic               o_done
);

  localparam int                 NB_WORD_BYTES = NB_DATA / NB_BYTE;
  localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(NB_WORD_BYTES - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE       = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] ADDR_ONE      = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] ADDR_ZERO     = {NB_ADDR{1'b0}};

  dump_state_e        r_state;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_ADDR-1:0] r_left;
  logic [IDX_W-1:0]   r_idx;
  logic               r_rd_enable;
  logic [NB_ADDR-1:0] r_rd_addr;
  logic               r_tx_start;
  logic               r_done;

  logic               w_load;
  logic               w_shift;
  logic [NB_BYTE-1:0] w_byte;

  // The shifter captures the word in LOAD; read data is valid exactly then.
  assign w_load  = (r_state == ST_LOAD);
  // Step to the next byte only when another byte of the same word follows.
  assign w_shift = (r_state == ST_WAIT) && bus.i_tx_done && (r_idx != LAST_IDX);

  du_word_shifter #(
    .NB_DATA   (NB_DATA),
    .NB_BYTE   (NB_BYTE),
    .LSB_FIRST (LSB_FIRST)
  ) u_shifter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_word  (bus.i_rd_data),
    .o_byte  (w_byte)
  );

  // Sequencer FSM with registered strobes (rd_enable, tx_start, done)
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= ADDR_ZERO;
      r_left      <= ADDR_ZERO;
      r_idx       <= {IDX_W{1'b0}};
      r_rd_enable <= 1'b0;
      r_rd_addr   <= ADDR_ZERO;
      r_tx_start  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below raises them.
      r_rd_enable <= 1'b0;
      r_tx_start  <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_count != ADDR_ZERO) begin
              r_addr      <= i_base_addr;
              r_left      <= i_count;
              r_rd_addr   <= i_base_addr;
              r_rd_enable <= 1'b1;
              r_state     <= ST_READ;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_idx      <= {IDX_W{1'b0}};
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_tx_done) begin
            if (r_idx != LAST_IDX) begin
              r_idx      <= r_idx + IDX_ONE;
              r_tx_start <= 1'b1;
              r_state    <= ST_SEND;
            end else if (r_left > ADDR_ONE) begin
              // Address wraps modulo 2^NB_ADDR by plain overflow.
              r_addr      <= r_addr + ADDR_ONE;
              r_rd_addr   <= r_addr + ADDR_ONE;
              r_left      <= r_left - ADDR_ONE;
              r_rd_enable <= 1'b1;
              r_state     <= ST_READ;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // o_done is the registered echo of DONE, so it shows in the
          // cycle after DONE while the FSM is already back in IDLE.
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_rd_enable = r_rd_enable;
  assign bus.o_rd_addr   = r_rd_addr;
  assign bus.o_tx_start  = r_tx_start;
  assign bus.o_tx_data   = w_byte;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;

endmodule : du_dump_sender

// File: tb/tb_du_dump_sender.sv
// -----------------------------------------------------------------------------
// tb_du_dump_sender
// Two instances share stimulus: dut_l sends low byte first, dut_m high byte
// first. 'sel' picks which one is started and observed. Expected read
// addresses and bytes are queued when a section is launched and popped as the
// selected DUT produces read strobes and tx_start pulses.
// -----------------------------------------------------------------------------
module tb_du_dump_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sel;
  logic        tx_done;
  logic [7:0]  base_v;
  logic [7:0]  count_v;
  logic        src_mode;
  logic [31:0] src_word;

  logic busy_l, done_l, busy_m, done_m;

  int vectors;
  int miscompares;

  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_byte_q[$];

  always #5 clk = ~clk;

  du_dump_sender_if bus_l ();
  du_dump_sender_if bus_m ();

  assign bus_l.i_tx_done = tx_done & ~sel;
  assign bus_m.i_tx_done = tx_done & sel;

  du_dump_sender #(.LSB_FIRST(1)) dut_l (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_start     (start & ~sel),
    .i_base_addr (base_v),
    .i_count     (count_v),
    .bus         (bus_l),
    .o_busy      (busy_l),
    .o_done      (done_l)
  );

  du_dump_sender #(.LSB_FIRST(0)) dut_m (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_start     (start & sel),
    .i_base_addr (base_v),
    .i_count     (count_v),
    .bus         (bus_m),
    .o_busy      (busy_m),
    .o_done      (done_m)
  );

  wire       w_rd_en    = sel ? bus_m.o_rd_enable : bus_l.o_rd_enable;
  wire [7:0] w_rd_addr  = sel ? bus_m.o_rd_addr   : bus_l.o_rd_addr;
  wire [7:0] w_tx_data  = sel ? bus_m.o_tx_data   : bus_l.o_tx_data;
  wire       w_tx_start = sel ? bus_m.o_tx_start  : bus_l.o_tx_start;
  wire       w_busy     = sel ? busy_m            : busy_l;
  wire       w_done     = sel ? done_m            : done_l;

  function automatic logic [31:0] src_val(input logic [7:0] a);
    return src_mode ? {4{a}} : src_word;
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] w, input int b, input bit lsb);
    logic [31:0] t;
    t = lsb ? (w >> (8 * b)) : (w >> (8 * (3 - b)));
    return t[7:0];
  endfunction

  // Synchronous-read source: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (bus_l.o_rd_enable) bus_l.i_rd_data <= src_val(bus_l.o_rd_addr);
    if (bus_m.o_rd_enable) bus_m.i_rd_data <= src_val(bus_m.o_rd_addr);
  end

  task automatic run_section(input bit use_msb, input int base, input int cnt,
                             input bit spurious, input bit mid_start, input string name);
    int cyc, n_rd, n_tx, n_done, n_busy, cd, spur, last_done;
    bit finished;
    logic [7:0] a, last_byte, e;
    sel = use_msb;
    exp_addr_q.delete();
    exp_byte_q.delete();
    for (int w = 0; w < cnt; w++) begin
      a = 8'(base + w);
      exp_addr_q.push_back(a);
      for (int b = 0; b < 4; b++) exp_byte_q.push_back(model_byte(src_val(a), b, !use_msb));
    end
    @(negedge clk);
    base_v = 8'(base);
    count_v = 8'(cnt);
    start = 1'b1;
    cyc = 0; n_rd = 0; n_tx = 0; n_done = 0; n_busy = 0; cd = 0; spur = 0;
    last_done = -1; finished = 1'b0; last_byte = 8'h00;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      tx_done = 1'b0;
      if (w_busy) n_busy++;
      if (w_rd_en) begin
        n_rd++;
        e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 8'hxx;
        vectors++;
        if (w_rd_addr !== e) begin
          miscompares++;
          $display("FAIL %s rd_addr: got %h expected %h", name, w_rd_addr, e);
        end
        if (spurious) spur = 2;
      end
      if (w_tx_start) begin
        n_tx++;
        vectors++;
        if (n_tx == 1) begin
          if (cyc != 3) begin
            miscompares++;
            $display("FAIL %s first_start_latency: got %0d expected 3", name, cyc);
          end
        end else if ((cyc - last_done) != (((n_tx - 1) % 4 == 0) ? 3 : 1)) begin
          miscompares++;
          $display("FAIL %s start_gap byte %0d: got %0d expected %0d", name, n_tx,
                   cyc - last_done, ((n_tx - 1) % 4 == 0) ? 3 : 1);
        end
        e = (exp_byte_q.size() > 0) ? exp_byte_q.pop_front() : 8'hxx;
        last_byte = e;
        vectors++;
        if (w_tx_data !== e) begin
          miscompares++;
          $display("FAIL %s tx_data byte %0d: got %h expected %h", name, n_tx, w_tx_data, e);
        end
        cd = 10;
        if (mid_start && n_tx == 5) begin
          base_v = 8'h40;
          count_v = 8'd7;
          start = 1'b1;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          vectors++;
          if (w_tx_data !== last_byte) begin
            miscompares++;
            $display("FAIL %s tx_data_hold: got %h expected %h", name, w_tx_data, last_byte);
          end
          tx_done = 1'b1;
          last_done = cyc;
        end
      end
      if (spur > 0) begin
        tx_done = 1'b1;
        spur--;
      end
      if (w_done) begin
        n_done++;
        finished = 1'b1;
        vectors++;
        if (cyc != ((cnt == 0) ? 2 : last_done + 2)) begin
          miscompares++;
          $display("FAIL %s done_latency: got cycle %0d expected %0d", name, cyc,
                   (cnt == 0) ? 2 : last_done + 2);
        end
      end
    end
    tx_done = 1'b0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL %s timeout: got no o_done expected o_done within 2000 cycles", name);
    end
    vectors++;
    if (n_rd != cnt || n_tx != 4 * cnt) begin
      miscompares++;
      $display("FAIL %s pulse_counts: got rd=%0d tx=%0d expected rd=%0d tx=%0d",
               name, n_rd, n_tx, cnt, 4 * cnt);
    end
    vectors++;
    if (n_busy != cyc - 1) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n_busy, cyc - 1);
    end
    @(negedge clk);
    vectors++;
    if (w_done !== 1'b0 || w_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse_width: got done=%b busy=%b expected 0 0", name, w_done, w_busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; tx_done = 1'b0;
    base_v = 8'h00; count_v = 8'h00; src_mode = 1'b0; src_word = 32'h0;
    #1;
    vectors++;
    if ({bus_l.o_rd_enable, bus_l.o_rd_addr, bus_l.o_tx_data, bus_l.o_tx_start, busy_l, done_l} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_l outputs: got %h expected 0",
               {bus_l.o_rd_enable, bus_l.o_rd_addr, bus_l.o_tx_data, bus_l.o_tx_start, busy_l, done_l});
    end
    vectors++;
    if ({bus_m.o_rd_enable, bus_m.o_rd_addr, bus_m.o_tx_data, bus_m.o_tx_start, busy_m, done_m} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_m outputs: got %h expected 0",
               {bus_m.o_rd_enable, bus_m.o_rd_addr, bus_m.o_tx_data, bus_m.o_tx_start, busy_m, done_m});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    src_mode = 1'b0;
    src_word = 32'hDEADBEEF;
    run_section(1'b0, 8'h05, 1, 1'b0, 1'b0, "single_lsb");
  endtask

  task automatic test_multi_wrap;
    src_mode = 1'b1;
    run_section(1'b0, 8'hFE, 3, 1'b0, 1'b0, "multi_wrap");
  endtask

  task automatic test_zero_count;
    run_section(1'b0, 8'h33, 0, 1'b0, 1'b0, "zero_count");
  endtask

  task automatic test_handshake;
    int bad;
    sel = 1'b0;
    bad = 0;
    // tx_done ticks while idle must leave the sequencer untouched
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_done = (i < 2);
      if (w_busy || w_tx_start || w_rd_en || w_done) bad++;
    end
    tx_done = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_tx_done: got %0d active cycles expected 0", bad);
    end
    src_mode = 1'b1;
    run_section(1'b0, 8'h20, 2, 1'b1, 1'b1, "handshake");
  endtask

  task automatic test_msb_order;
    src_mode = 1'b0;
    src_word = 32'h01234567;
    run_section(1'b1, 8'h10, 1, 1'b0, 1'b0, "msb_order");
  endtask

  task automatic test_reset_mid;
    int cyc, n_tx, cd, bad;
    sel = 1'b0;
    src_mode = 1'b0;
    src_word = 32'hCAFEF00D;
    @(negedge clk);
    base_v = 8'h0A; count_v = 8'd2; start = 1'b1;
    cyc = 0; n_tx = 0; cd = 0;
    while (n_tx < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      tx_done = 1'b0;
      if (w_tx_start) begin
        n_tx++;
        cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
    end
    vectors++;
    if (n_tx < 2) begin
      miscompares++;
      $display("FAIL reset_mid reach_byte2: got %0d starts expected 2", n_tx);
    end
    // One cycle after byte 2's start the FSM sits in WAIT
    @(negedge clk);
    tx_done = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({w_rd_en, w_rd_addr, w_tx_data, w_tx_start, w_busy, w_done} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got %h expected 0",
               {w_rd_en, w_rd_addr, w_tx_data, w_tx_start, w_busy, w_done});
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_done) bad++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    tx_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (w_done || w_busy || w_tx_start) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_mid late_activity: got %0d active cycles expected 0", bad);
    end
    run_section(1'b0, 8'h0B, 1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_word();
    test_multi_wrap();
    test_zero_count();
    test_handshake();
    test_msb_order();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_du_dump_sender
